// File: rtl/wddl_pkg.sv
// Shared types and constant helpers for the WDDL XOR reduction tree.
// Phase encoding, error counter width and tree-shape functions.
package wddl_pkg;

   typedef enum logic {
      PH_PRECH = 1'b0,
      PH_EVAL  = 1'b1
   } phase_e;

   localparam int ERR_CNT_W = 8;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

   // operands present at tree level l
   function automatic int lvl_cnt(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction

   // operand offset of level l inside the flattened tree bus
   function automatic int lvl_off(input int n, input int l);
      int s;
      s = 0;
      for (int j = 0; j < l; j++) s += lvl_cnt(n, j);
      return s;
   endfunction

endpackage

// File: rtl/wddl_xor_level.sv
// One level of the dual-rail XOR tree: pairwise XOR2 nodes, odd operand
// passed through, optionally registered with its valid bit.
module wddl_xor_level #(
   parameter  int WIDTH = 8,
   parameter  int N_I   = 2,
   parameter  int REG   = 1,
   localparam int N_O   = (N_I + 1) / 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_v,
   input  logic [N_I*WIDTH-1:0]   i_p,
   input  logic [N_I*WIDTH-1:0]   i_n,
   output logic                   o_v,
   output logic [N_O*WIDTH-1:0]   o_p,
   output logic [N_O*WIDTH-1:0]   o_n
);

   logic [N_O*WIDTH-1:0] w_p;
   logic [N_O*WIDTH-1:0] w_n;

   always_comb begin
      w_p = '0;
      w_n = '0;
      for (int k = 0; k < N_I / 2; k++) begin
         w_p[k*WIDTH +: WIDTH] =
            (i_p[2*k*WIDTH +: WIDTH] & i_n[(2*k+1)*WIDTH +: WIDTH]) |
            (i_n[2*k*WIDTH +: WIDTH] & i_p[(2*k+1)*WIDTH +: WIDTH]);
         w_n[k*WIDTH +: WIDTH] =
            (i_p[2*k*WIDTH +: WIDTH] & i_p[(2*k+1)*WIDTH +: WIDTH]) |
            (i_n[2*k*WIDTH +: WIDTH] & i_n[(2*k+1)*WIDTH +: WIDTH]);
      end
      if (N_I % 2 == 1) begin
         w_p[(N_O-1)*WIDTH +: WIDTH] = i_p[(N_I-1)*WIDTH +: WIDTH];
         w_n[(N_O-1)*WIDTH +: WIDTH] = i_n[(N_I-1)*WIDTH +: WIDTH];
      end
   end

   if (REG != 0) begin : g_reg
      logic                 r_v;
      logic [N_O*WIDTH-1:0] r_p;
      logic [N_O*WIDTH-1:0] r_n;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_v <= 1'b0;
            r_p <= '0;
            r_n <= '0;
         end else begin
            r_v <= i_v;
            r_p <= w_p;
            r_n <= w_n;
         end
      end

      assign o_v = r_v;
      assign o_p = r_p;
      assign o_n = r_n;
   end else begin : g_comb
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_v = i_v;
      assign o_p = w_p;
      assign o_n = w_n;
   end

endmodule

// File: rtl/wddl_xor_tree_pipe.sv
// Pipelined N-input WDDL XOR tree with precharge/evaluate sequencing,
// input handshake and sticky dual-rail integrity checking.
module wddl_xor_tree_pipe
   import wddl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 4,
   parameter int PIPE  = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [N_IN*WIDTH-1:0] d_p_in,
   input  logic [N_IN*WIDTH-1:0] d_n_in,
   output logic [WIDTH-1:0]      d_p_out,
   output logic [WIDTH-1:0]      d_n_out,
   output logic                  valid_out,
   output logic                  phase_out,
   output logic                  err_out,
   output logic [ERR_CNT_W-1:0]  err_cnt_out
);

   localparam int L   = clog2(N_IN);
   localparam int TOT = lvl_off(N_IN, L + 1);
   localparam int OL  = lvl_off(N_IN, L);

   phase_e r_phase;
   phase_e w_phase_nxt;
   logic   w_acc;
   logic   w_viol;

   logic                  r_iv;
   logic [N_IN*WIDTH-1:0] r_ip;
   logic [N_IN*WIDTH-1:0] r_in;
   logic                  r_err;
   logic [ERR_CNT_W-1:0]  r_cnt;

   logic [TOT*WIDTH-1:0]  w_tp;
   logic [TOT*WIDTH-1:0]  w_tn;
   logic [L:0]            w_tv;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) r_phase <= PH_PRECH;
      else           r_phase <= w_phase_nxt;
   end

   always_comb begin
      w_phase_nxt = PH_PRECH;
      unique case (r_phase)
         PH_PRECH: w_phase_nxt = PH_EVAL;
         PH_EVAL:  w_phase_nxt = PH_PRECH;
      endcase
   end

   assign ready_out = (r_phase == PH_EVAL);
   assign phase_out = r_phase;
   assign w_acc     = valid_in & ready_out;
   // a bit with equal rails is either a spacer or a collision
   assign w_viol    = w_acc & ~&(d_p_in ^ d_n_in);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_iv  <= 1'b0;
         r_ip  <= '0;
         r_in  <= '0;
         r_err <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_iv  <= w_acc;
         r_ip  <= w_acc ? d_p_in : '0;
         r_in  <= w_acc ? d_n_in : '0;
         r_err <= r_err | w_viol;
         if (w_viol && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign err_out     = r_err;
   assign err_cnt_out = r_cnt;

   assign w_tv[0]                  = r_iv;
   assign w_tp[N_IN*WIDTH-1:0]     = r_ip;
   assign w_tn[N_IN*WIDTH-1:0]     = r_in;

   for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int NI = lvl_cnt(N_IN, l);
      localparam int NO = lvl_cnt(N_IN, l + 1);
      localparam int OI = lvl_off(N_IN, l);
      localparam int OO = lvl_off(N_IN, l + 1);

      wddl_xor_level #(
         .WIDTH (WIDTH),
         .N_I   (NI),
         .REG   (PIPE)
      ) u_lvl (
         .i_clk   (clk_in),
         .i_rst_n (rst_n_in),
         .i_v     (w_tv[l]),
         .i_p     (w_tp[OI*WIDTH +: NI*WIDTH]),
         .i_n     (w_tn[OI*WIDTH +: NI*WIDTH]),
         .o_v     (w_tv[l+1]),
         .o_p     (w_tp[OO*WIDTH +: NO*WIDTH]),
         .o_n     (w_tn[OO*WIDTH +: NO*WIDTH])
      );
   end

   if (PIPE == 0 && L > 0) begin : g_oreg
      logic             r_ov;
      logic [WIDTH-1:0] r_op;
      logic [WIDTH-1:0] r_on;

      always_ff @(posedge clk_in) begin
         if (!rst_n_in) begin
            r_ov <= 1'b0;
            r_op <= '0;
            r_on <= '0;
         end else begin
            r_ov <= w_tv[L];
            r_op <= w_tp[OL*WIDTH +: WIDTH];
            r_on <= w_tn[OL*WIDTH +: WIDTH];
         end
      end

      assign valid_out = r_ov;
      assign d_p_out   = r_op;
      assign d_n_out   = r_on;
   end else begin : g_onone
      assign valid_out = w_tv[L];
      assign d_p_out   = w_tp[OL*WIDTH +: WIDTH];
      assign d_n_out   = w_tn[OL*WIDTH +: WIDTH];
   end

endmodule

// File: tb/tb_wddl_xor_tree_pipe.sv
// Directed bench for wddl_xor_tree_pipe: default 4-input pipe plus
// 5-input pipelined and unpipelined instances on a shared handshake.
module tb_wddl_xor_tree_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vin;
   logic [31:0] p4, n4;
   logic [39:0] p5, n5;

   logic       rdy4, vo4, ph4, er4;
   logic [7:0] op4, on4, ec4;
   logic       rdy5, vo5, ph5, er5;
   logic [7:0] op5, on5, ec5;
   logic       rdyc, voc, phc, erc;
   logic [7:0] opc, onc, ecc;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] q_p[$];

   always #5 clk = ~clk;

   wddl_xor_tree_pipe #(.WIDTH(8), .N_IN(4), .PIPE(1)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(vin),
      .ready_out(rdy4), .d_p_in(p4), .d_n_in(n4),
      .d_p_out(op4), .d_n_out(on4), .valid_out(vo4),
      .phase_out(ph4), .err_out(er4), .err_cnt_out(ec4)
   );

   wddl_xor_tree_pipe #(.WIDTH(8), .N_IN(5), .PIPE(1)) dut5 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(vin),
      .ready_out(rdy5), .d_p_in(p5), .d_n_in(n5),
      .d_p_out(op5), .d_n_out(on5), .valid_out(vo5),
      .phase_out(ph5), .err_out(er5), .err_cnt_out(ec5)
   );

   wddl_xor_tree_pipe #(.WIDTH(8), .N_IN(5), .PIPE(0)) dut5c (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(vin),
      .ready_out(rdyc), .d_p_in(p5), .d_n_in(n5),
      .d_p_out(opc), .d_n_out(onc), .valid_out(voc),
      .phase_out(phc), .err_out(erc), .err_cnt_out(ecc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_eval();
      for (int i = 0; i < 4; i++) begin
         if (ph4 === 1'b1) return;
         tick();
      end
      chk("wait_eval", {31'd0, ph4}, 32'd1);
   endtask

   function automatic logic [7:0] ref4(input logic [31:0] p);
      return p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24];
   endfunction

   initial begin
      int acc, res, adj;
      logic prev;
      logic [7:0] e;

      rst_n = 1'b0;
      vin   = 1'b0;
      p4 = $urandom; n4 = $urandom;
      p5 = {$urandom, $urandom}; n5 = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         vin = 1'($urandom);
         p4 = $urandom; n4 = $urandom;
         tick();
      end
      chk("rst_dp", {24'd0, op4}, 32'h0);
      chk("rst_dn", {24'd0, on4}, 32'h0);
      chk("rst_vout", {31'd0, vo4}, 32'h0);
      chk("rst_ready", {31'd0, rdy4}, 32'h0);
      chk("rst_err", {31'd0, er4}, 32'h0);
      chk("rst_cnt", {24'd0, ec4}, 32'h0);

      vin   = 1'b0;
      rst_n = 1'b1;
      chk("ph0", {31'd0, ph4}, 32'd0);
      tick();
      chk("ph1", {31'd0, ph4}, 32'd1);
      tick();
      chk("ph2", {31'd0, ph4}, 32'd0);
      tick();
      chk("ph3", {31'd0, ph4}, 32'd1);
      chk("rdy_eval", {31'd0, rdy4}, 32'd1);

      // basic word; N_IN=5 instances get one-hot operands
      p4 = 32'h5533F00F; n4 = ~p4;
      p5 = 40'h10_08_04_02_01; n5 = ~p5;
      vin = 1'b1;
      tick();
      vin = 1'b0;
      p4 = 32'h0; n4 = 32'hFFFFFFFF;
      p5 = 40'h0; n5 = '1;
      chk("c5_early_v", {31'd0, voc}, 32'd0);
      tick();
      chk("c5_v", {31'd0, voc}, 32'd1);
      chk("c5_p", {24'd0, opc}, 32'h1F);
      chk("c5_n", {24'd0, onc}, 32'hE0);
      chk("b_early_v", {31'd0, vo4}, 32'd0);
      tick();
      chk("b_v", {31'd0, vo4}, 32'd1);
      chk("b_p", {24'd0, op4}, 32'h99);
      chk("b_n", {24'd0, on4}, 32'h66);
      chk("c5_after_v", {31'd0, voc}, 32'd0);
      tick();
      chk("b_after_v", {31'd0, vo4}, 32'd0);
      chk("b_after_p", {24'd0, op4}, 32'h0);
      chk("b_after_n", {24'd0, on4}, 32'h0);
      chk("p5_v", {31'd0, vo5}, 32'd1);
      chk("p5_p", {24'd0, op5}, 32'h1F);
      chk("p5_n", {24'd0, on5}, 32'hE0);
      for (int i = 0; i < 4; i++) tick();

      // valid held for 10 cycles against a reference XOR
      acc = 0; res = 0; adj = 0; prev = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (vo4) begin
            res++;
            if (prev) adj++;
            if (q_p.size() == 0) begin
               chk("stream_extra", 32'd1, 32'd0);
            end else begin
               e = q_p.pop_front();
               chk("stream_p", {24'd0, op4}, {24'd0, e});
               chk("stream_n", {24'd0, on4}, {24'd0, ~e});
            end
         end else begin
            chk("stream_spacer", {16'd0, op4, on4}, 32'd0);
         end
         prev = vo4;
         vin = (c < 10);
         p4 = $urandom; n4 = ~p4;
         if (c < 10 && rdy4) begin
            acc++;
            q_p.push_back(ref4(p4));
         end
         tick();
      end
      vin = 1'b0;
      chk("stream_acc", acc, 5);
      chk("stream_res", res, 5);
      chk("stream_adj", adj, 0);

      // integrity: operand0 p=n=1 on bit0, others zero-valued
      wait_eval();
      p4 = 32'h00000001; n4 = 32'hFFFFFF01;
      vin = 1'b1;
      tick();
      vin = 1'b0;
      p4 = 32'h0; n4 = 32'hFFFFFFFF;
      chk("viol_err", {31'd0, er4}, 32'd1);
      chk("viol_cnt", {24'd0, ec4}, 32'd1);
      tick();
      tick();
      chk("viol_v", {31'd0, vo4}, 32'd1);
      chk("viol_p", {16'd0, op4, on4}, 32'h0101);

      wait_eval();
      p4 = 32'h12345678; n4 = ~p4;
      vin = 1'b1;
      tick();
      vin = 1'b0;
      chk("clean_err", {31'd0, er4}, 32'd1);
      chk("clean_cnt", {24'd0, ec4}, 32'd1);

      p4 = 32'hFF; n4 = 32'hFF;
      for (int i = 0; i < 300; i++) begin
         wait_eval();
         vin = 1'b1;
         tick();
         vin = 1'b0;
      end
      chk("sat_cnt", {24'd0, ec4}, 32'd255);
      chk("sat_err", {31'd0, er4}, 32'd1);
      for (int i = 0; i < 4; i++) tick();

      // reset one cycle after accepting a (violating) word
      wait_eval();
      vin = 1'b1;
      tick();
      vin = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_err", {31'd0, er4}, 32'd0);
      chk("mid_cnt", {24'd0, ec4}, 32'd0);
      chk("mid_ph", {31'd0, ph4}, 32'd0);
      res = 0;
      for (int i = 0; i < 6; i++) begin
         if (vo4 || (op4 != 8'h0) || (on4 != 8'h0)) res++;
         tick();
      end
      chk("mid_no_vout", res, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
